// File: rtl/shake_rng_fifo.sv
// shake_rng_fifo: packs pairs of SHAKE256 squeeze lanes into 2*LANE_W
// words and buffers them in a show-ahead FIFO feeding the Gaussian sampler.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous discard of all buffered data (reseed)
//   in_valid      squeeze lane valid
//   in_data       squeeze lane (LANE_W bits)
//   in_ready      lane accepted when in_valid && in_ready
//   rng_valid     rng holds an unconsumed word
//   rng           head word {second lane, first lane}, zero when invalid
//   rng_extract   sampler consumed the current rng word (1-cycle pulse)
//   level         number of full entries, 0..DEPTH
//   underflow     sticky flag: rng_extract seen while rng_valid == 0
//   word_cnt      successful pop count (only with RNG_WORD_CNT_EN)
//
// Optional feature: define RNG_WORD_CNT_EN to add the word_cnt output.
module shake_rng_fifo #(
   parameter int DEPTH  = 4,
   parameter int LANE_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [LANE_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     rng_valid,
   output logic [2*LANE_W-1:0]      rng,
   input  logic                     rng_extract,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow
`ifdef RNG_WORD_CNT_EN
   ,
   output logic [31:0]              word_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = 2 * LANE_W;

   logic [WW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_q;
   logic [AW-1:0]     rd_q;
   logic [LW-1:0]     lvl_q;
   logic [LANE_W-1:0] lo_q;
   logic              half_q;
   logic              rdy_q;
   logic              uf_q;

   logic full;
   logic lane_acc;
   logic word_push;
   logic pop;

   assign full = (lvl_q == LW'(DEPTH));

   // rdy_q holds in_ready low through reset and opens it one edge later.
   // A first-half lane is still taken when full; only the pair-completing
   // lane must wait for space.
   assign in_ready = rdy_q && !flush && !(half_q && full);

   assign lane_acc  = in_valid && in_ready;
   assign word_push = lane_acc && half_q;
   assign rng_valid = (lvl_q != '0);
   assign pop       = rng_extract && rng_valid;

   assign rng       = rng_valid ? mem[rd_q] : '0;
   assign level     = lvl_q;
   assign underflow = uf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   // Storage is never reset; occupancy is governed by level only.
   always_ff @(posedge clk) begin
      if (word_push) begin
         mem[wr_q] <= {in_data, lo_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_q <= 1'b0;
         lo_q   <= '0;
      end else if (flush) begin
         half_q <= 1'b0;
      end else if (lane_acc) begin
         half_q <= !half_q;
         if (!half_q) begin
            lo_q <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (word_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         unique case ({word_push, pop})
            2'b10:   lvl_q <= lvl_q + 1'b1;
            2'b01:   lvl_q <= lvl_q - 1'b1;
            default: lvl_q <= lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uf_q <= 1'b0;
      end else if (flush) begin
         uf_q <= 1'b0;
      end else if (rng_extract && !rng_valid) begin
         uf_q <= 1'b1;
      end
   end

`ifdef RNG_WORD_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign word_cnt = cnt_q;
`endif

endmodule
